// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Groups the three buses that meet at the data-memory arbiter:
//   core load/store port (cpu_*), DMA/debug requester (dma_*) and the
//   Data_Memory port (mem_*).
//   modport slave  : the arbiter's view
//   modport master : the surrounding core/DMA/memory environment's view
interface dmem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  cpu_mem_read_i;
  logic                  cpu_mem_write_i;
  logic [ADDR_WIDTH-1:0] cpu_addr_i;
  logic [DATA_WIDTH-1:0] cpu_wdata_i;
  logic [DATA_WIDTH-1:0] cpu_rdata_o;
  logic                  cpu_stall_o;

  logic                  dma_req_i;
  logic                  dma_we_i;
  logic [ADDR_WIDTH-1:0] dma_addr_i;
  logic [DATA_WIDTH-1:0] dma_wdata_i;
  logic                  dma_gnt_o;
  logic                  dma_rvalid_o;
  logic [DATA_WIDTH-1:0] dma_rdata_o;

  logic                  mem_read_o;
  logic                  mem_write_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  cpu_mem_read_i, cpu_mem_write_i, cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_stall_o,
    input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    output dma_gnt_o, dma_rvalid_o, dma_rdata_o,
    output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output cpu_mem_read_i, cpu_mem_write_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_stall_o,
    output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    input  dma_gnt_o, dma_rvalid_o, dma_rdata_o,
    input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one Data_Memory between the single-cycle core load/store port and
//   a DMA/debug requester. The core has priority; DMA uses idle core slots and
//   is forced in after MAX_WAIT denied cycles for up to MAX_BURST beats, during
//   which cpu_stall_o must hold the PC and suppress Reg_Write.
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : dmem_arbiter_if.slave (cpu_*, dma_*, mem_* signal groups)
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {ARB_CPU, ARB_FORCE} state_t;

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic          FORCE_EN   = (MAX_BURST > 1);

  state_t         state, state_n;
  logic [WW-1:0]  wait_cnt, wait_n;
  logic [BW-1:0]  burst_cnt, burst_n;
  logic           cpu_acc;
  logic           gnt, stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ARB_CPU;
      wait_cnt         <= '0;
      burst_cnt        <= '0;
      bus.dma_rvalid_o <= 1'b0;
      bus.dma_rdata_o  <= '0;
    end else begin
      state            <= state_n;
      wait_cnt         <= wait_n;
      burst_cnt        <= burst_n;
      bus.dma_rvalid_o <= gnt & ~bus.dma_we_i;
      if (gnt & ~bus.dma_we_i)
        bus.dma_rdata_o <= bus.mem_rdata_i;
    end
  end

  always_comb begin
    cpu_acc = bus.cpu_mem_read_i | bus.cpu_mem_write_i;
    gnt     = 1'b0;
    stall   = 1'b0;
    state_n = state;
    burst_n = burst_cnt;
    wait_n  = wait_cnt;

    unique case (state)
      ARB_CPU: begin
        gnt   = bus.dma_req_i & (~cpu_acc | (wait_cnt == WAIT_MAX));
        stall = cpu_acc & gnt;
        if (gnt & cpu_acc & FORCE_EN) begin
          state_n = ARB_FORCE;
          burst_n = BW'(1);
        end
      end
      ARB_FORCE: begin
        gnt   = bus.dma_req_i;
        stall = cpu_acc;
        if (gnt)
          burst_n = burst_cnt + BW'(1);
        if (~bus.dma_req_i | (gnt & (burst_cnt == BURST_LAST))) begin
          state_n = ARB_CPU;
          burst_n = '0;
        end
      end
      default: state_n = ARB_CPU;
    endcase

    if (gnt | ~bus.dma_req_i)
      wait_n = '0;
    else if (wait_cnt != WAIT_MAX)
      wait_n = wait_cnt + WW'(1);

    // Everything is forced quiet while reset is held; the registers are
    // cleared asynchronously so nothing is committed on a reset edge.
    if (reset) begin
      gnt   = 1'b0;
      stall = 1'b0;
    end
  end

  assign bus.dma_gnt_o   = gnt;
  assign bus.cpu_stall_o = stall;
  assign bus.cpu_rdata_o = bus.mem_rdata_i;

  // In ARB_FORCE with the DMA request withdrawn the core is still stalled but
  // the memory port falls back to it; its store is masked so a stalled store
  // never reaches memory (the core re-presents it next cycle).
  assign bus.mem_write_o = ~reset & (gnt ? bus.dma_we_i  : (bus.cpu_mem_write_i & ~stall));
  assign bus.mem_read_o  = ~reset & (gnt ? ~bus.dma_we_i : bus.cpu_mem_read_i);
  assign bus.mem_addr_o  = gnt ? bus.dma_addr_i  : bus.cpu_addr_i;
  assign bus.mem_wdata_o = gnt ? bus.dma_wdata_i : bus.cpu_wdata_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed scenarios plus a randomized run checked against a cycle-level
//   reference built from the arbitration rules (denied-cycle count, takeover
//   beat count) and a reference copy of memory.
module tb_dmem_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int MW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];

  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Data_Memory stand-in: combinational read, write at rising edge.
  assign bus.mem_rdata_i = mem[bus.mem_addr_o[7:2]];
  always @(posedge clk)
    if (bus.mem_write_o) mem[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;

  task automatic set_cpu(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_mem_read_i = rd; bus.cpu_mem_write_i = wr; bus.cpu_addr_i = a; bus.cpu_wdata_i = d;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.dma_req_i = req; bus.dma_we_i = we; bus.dma_addr_i = a; bus.dma_wdata_i = d;
  endtask

  // One quiet cycle: DMA request low returns the arbiter to ARB_CPU with wait_cnt 0.
  task automatic idle_cycle();
    set_cpu(0, 0, 0, 0); set_dma(0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_cpu(0, 1, 32'h4, 32'h55); set_dma(1, 1, 32'h8, 32'h66);
    #1;
    total++; if (bus.dma_gnt_o !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=0", bus.dma_gnt_o); end
    total++; if (bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.cpu_stall_o); end
    total++; if (bus.mem_write_o !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%b exp=0", bus.mem_write_o); end
    total++; if (bus.mem_read_o !== 1'b0) begin bad++; $display("FAIL reset_mem_read got=%b exp=0", bus.mem_read_o); end
    total++; if (bus.dma_rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", bus.dma_rvalid_o); end
    total++; if (bus.dma_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.dma_rdata_o); end
    @(negedge clk);
    reset = 1'b0;
    idle_cycle();
  endtask

  task automatic test_idle_steal();
    set_cpu(0, 0, 0, 0); set_dma(1, 1, 32'h10, 32'hDEADBEEF);
    #1;
    total++; if (bus.dma_gnt_o !== 1'b1) begin bad++; $display("FAIL steal_gnt got=%b exp=1", bus.dma_gnt_o); end
    total++; if (bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL steal_stall got=%b exp=0", bus.cpu_stall_o); end
    total++; if (bus.mem_write_o !== 1'b1 || bus.mem_addr_o !== 32'h10) begin bad++; $display("FAIL steal_mem got=%b/%h exp=1/00000010", bus.mem_write_o, bus.mem_addr_o); end
    @(negedge clk);
    set_dma(0, 0, 0, 0); set_cpu(1, 0, 32'h10, 0);
    #1;
    total++; if (bus.cpu_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL steal_lw got=%h exp=deadbeef", bus.cpu_rdata_o); end
    total++; if (bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL steal_lw_stall got=%b exp=0", bus.cpu_stall_o); end
    @(negedge clk);
    idle_cycle();
  endtask

  // Core busy every cycle with a DMA read held: MW denied cycles, then a forced beat.
  task automatic test_starvation();
    set_cpu(1, 0, 32'h4, 0); set_dma(1, 0, 32'h8, 0);
    for (int i = 1; i <= MW; i++) begin
      #1;
      total++; if (bus.dma_gnt_o !== 1'b0 || bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL starve_deny%0d got=%b%b exp=00", i, bus.dma_gnt_o, bus.cpu_stall_o); end
      @(negedge clk);
    end
    #1;
    total++; if (bus.dma_gnt_o !== 1'b1 || bus.cpu_stall_o !== 1'b1) begin bad++; $display("FAIL starve_force got=%b%b exp=11", bus.dma_gnt_o, bus.cpu_stall_o); end
    @(negedge clk);
  endtask

  // Continues the takeover from test_starvation (one beat already taken).
  task automatic test_burst_cap();
    int grants;
    grants = 1;
    for (int i = 2; i <= MB + 1; i++) begin
      #1;
      if (bus.dma_gnt_o === 1'b1 && bus.cpu_stall_o === 1'b1) grants++;
      if (i == MB + 1) begin
        total++; if (bus.dma_gnt_o !== 1'b0 || bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL burst_release got=%b%b exp=00", bus.dma_gnt_o, bus.cpu_stall_o); end
      end
      @(negedge clk);
    end
    total++; if (grants != MB) begin bad++; $display("FAIL burst_count got=%0d exp=%0d", grants, MB); end
    // Release cycle was denied #1; MW-1 more denials then a grant.
    for (int i = 2; i <= MW; i++) begin
      #1;
      total++; if (bus.dma_gnt_o !== 1'b0) begin bad++; $display("FAIL burst_rewait%0d got=%b exp=0", i, bus.dma_gnt_o); end
      @(negedge clk);
    end
    #1;
    total++; if (bus.dma_gnt_o !== 1'b1) begin bad++; $display("FAIL burst_reforce got=%b exp=1", bus.dma_gnt_o); end
    @(negedge clk);
    idle_cycle();
  endtask

  task automatic test_dma_read();
    set_cpu(0, 1, 32'h20, 32'h12345678); set_dma(0, 0, 0, 0);
    @(negedge clk);
    set_cpu(0, 0, 0, 0); set_dma(1, 0, 32'h20, 0);
    #1;
    total++; if (bus.dma_gnt_o !== 1'b1 || bus.mem_read_o !== 1'b1) begin bad++; $display("FAIL rd_gnt got=%b%b exp=11", bus.dma_gnt_o, bus.mem_read_o); end
    @(negedge clk);
    set_dma(0, 0, 0, 0);
    total++; if (bus.dma_rvalid_o !== 1'b1) begin bad++; $display("FAIL rd_rvalid got=%b exp=1", bus.dma_rvalid_o); end
    total++; if (bus.dma_rdata_o !== 32'h12345678) begin bad++; $display("FAIL rd_rdata got=%h exp=12345678", bus.dma_rdata_o); end
    @(negedge clk);
    total++; if (bus.dma_rvalid_o !== 1'b0) begin bad++; $display("FAIL rd_rvalid_low got=%b exp=0", bus.dma_rvalid_o); end
    total++; if (bus.dma_rdata_o !== 32'h12345678) begin bad++; $display("FAIL rd_hold got=%h exp=12345678", bus.dma_rdata_o); end
  endtask

  task automatic test_collision();
    set_cpu(0, 1, 32'h30, 32'h1); set_dma(1, 1, 32'h30, 32'h2);
    repeat (MW) @(negedge clk);
    #1;
    total++; if (bus.dma_gnt_o !== 1'b1 || bus.cpu_stall_o !== 1'b1 || bus.mem_wdata_o !== 32'h2) begin bad++; $display("FAIL coll_force got=%b%b/%h exp=11/00000002", bus.dma_gnt_o, bus.cpu_stall_o, bus.mem_wdata_o); end
    @(negedge clk);
    total++; if (mem[12] !== 32'h2) begin bad++; $display("FAIL coll_dma_word got=%h exp=00000002", mem[12]); end
    set_dma(0, 0, 0, 0);
    #1;
    // Still in the takeover: core stalled, its store must not land.
    total++; if (bus.cpu_stall_o !== 1'b1 || bus.mem_write_o !== 1'b0) begin bad++; $display("FAIL coll_tail got=%b%b exp=10", bus.cpu_stall_o, bus.mem_write_o); end
    @(negedge clk);
    #1;
    total++; if (bus.cpu_stall_o !== 1'b0 || bus.mem_write_o !== 1'b1) begin bad++; $display("FAIL coll_cpu got=%b%b exp=01", bus.cpu_stall_o, bus.mem_write_o); end
    @(negedge clk);
    total++; if (mem[12] !== 32'h1) begin bad++; $display("FAIL coll_final got=%h exp=00000001", mem[12]); end
    idle_cycle();
  endtask

  task automatic test_reset_mid_force();
    set_cpu(0, 1, 32'h34, 32'h77); set_dma(1, 1, 32'h38, 32'h99);
    repeat (MW + 1) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (bus.dma_gnt_o !== 1'b0 || bus.cpu_stall_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin bad++; $display("FAIL mid_reset got=%b%b%b exp=000", bus.dma_gnt_o, bus.cpu_stall_o, bus.mem_write_o); end
    total++; if (bus.dma_rdata_o !== 32'h0) begin bad++; $display("FAIL mid_reset_rdata got=%h exp=0", bus.dma_rdata_o); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= MW; i++) begin
      #1;
      total++; if (bus.dma_gnt_o !== 1'b0) begin bad++; $display("FAIL post_reset_deny%0d got=%b exp=0", i, bus.dma_gnt_o); end
      @(negedge clk);
    end
    for (int i = 1; i <= MB; i++) begin
      #1;
      total++; if (bus.dma_gnt_o !== 1'b1 || bus.cpu_stall_o !== 1'b1) begin bad++; $display("FAIL post_reset_beat%0d got=%b%b exp=11", i, bus.dma_gnt_o, bus.cpu_stall_o); end
      @(negedge clk);
    end
    #1;
    total++; if (bus.dma_gnt_o !== 1'b0) begin bad++; $display("FAIL post_reset_release got=%b exp=0", bus.dma_gnt_o); end
    @(negedge clk);
    idle_cycle();
  endtask

  task automatic test_random();
    int denied, beats;
    bit takeover, pending, cpu_hold;
    bit p_we, c_rd, c_wr, e_gnt, e_stall, e_mw, e_rv;
    logic [31:0] p_addr, p_wdata, c_addr, c_wdata, e_rd;
    denied = 0; beats = 0; takeover = 0; pending = 0; cpu_hold = 0;
    c_rd = 0; c_wr = 0; c_addr = 0; c_wdata = 0; p_we = 0; p_addr = 0; p_wdata = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!pending && $urandom_range(0, 2) == 0) begin
        pending = 1; p_we = 1'($urandom_range(0, 1));
        p_addr = 32'h40 + 32'($urandom_range(0, 7)) * 4; p_wdata = $urandom;
      end
      if (!cpu_hold) begin
        case ($urandom_range(0, 3))
          0: begin c_rd = 0; c_wr = 0; end
          1: begin c_rd = 1; c_wr = 0; end
          default: begin c_rd = 0; c_wr = 1; end
        endcase
        c_addr = 32'h40 + 32'($urandom_range(0, 7)) * 4; c_wdata = $urandom;
      end
      set_cpu(c_rd, c_wr, c_addr, c_wdata);
      set_dma(pending, p_we, p_addr, p_wdata);

      e_gnt   = pending && (takeover || !(c_rd || c_wr) || denied >= MW);
      e_stall = takeover ? (c_rd || c_wr) : ((c_rd || c_wr) && e_gnt);
      e_mw    = e_gnt ? p_we : (c_wr && !e_stall);
      e_rv    = e_gnt && !p_we;
      e_rd    = ref_mem[p_addr[7:2]];
      #1;
      total++; if (bus.dma_gnt_o !== e_gnt) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, bus.dma_gnt_o, e_gnt); end
      total++; if (bus.cpu_stall_o !== e_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, bus.cpu_stall_o, e_stall); end
      total++; if (bus.mem_write_o !== e_mw) begin bad++; $display("FAIL rnd_mem_write cyc=%0d got=%b exp=%b", cyc, bus.mem_write_o, e_mw); end
      if (c_rd && !e_stall) begin
        total++; if (bus.cpu_rdata_o !== ref_mem[c_addr[7:2]]) begin bad++; $display("FAIL rnd_cpu_rdata cyc=%0d got=%h exp=%h", cyc, bus.cpu_rdata_o, ref_mem[c_addr[7:2]]); end
      end

      if (e_gnt && p_we) ref_mem[p_addr[7:2]] = p_wdata;
      if (c_wr && !e_stall) ref_mem[c_addr[7:2]] = c_wdata;
      if (e_gnt || !pending) denied = 0;
      else if (denied < MW) denied++;
      if (takeover) begin
        if (!pending) begin takeover = 0; beats = 0; end
        else begin beats++; if (beats >= MB) begin takeover = 0; beats = 0; end end
      end else if (e_gnt && (c_rd || c_wr) && MB > 1) begin
        takeover = 1; beats = 1;
      end
      if (e_gnt) pending = 0;
      cpu_hold = e_stall;

      @(negedge clk);
      total++; if (bus.dma_rvalid_o !== e_rv) begin bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, bus.dma_rvalid_o, e_rv); end
      if (e_rv) begin
        total++; if (bus.dma_rdata_o !== e_rd) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, bus.dma_rdata_o, e_rd); end
      end
    end
    for (int i = 16; i < 24; i++) begin
      total++; if (mem[i] !== ref_mem[i]) begin bad++; $display("FAIL rnd_mem word=%0d got=%h exp=%h", i, mem[i], ref_mem[i]); end
    end
    idle_cycle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    set_cpu(0, 0, 0, 0); set_dma(0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_idle_steal();
    test_starvation();
    test_burst_cap();
    test_dma_read();
    test_collision();
    test_reset_mid_force();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
